// File: rtl/mii_mgmt.sv
// Purpose : MDIO (clause-22) management master; serialises one 64-bit read or write frame per request.
// Latency : ack pulses 64 mdc periods (64 * 2^(DIV_LOG2+1) clk) after the bit boundary that accepted req.
// Backpressure: req is a held level; it is only looked at on bit boundaries while idle, ignored mid-frame.
module mii_mgmt #(
   parameter int DIV_LOG2 = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  phyad,
   input  logic [4:0]  addr,
   input  logic [15:0] wdata,
   input  logic        req,
   input  logic        we,
   output logic        ack,
   output logic [15:0] rdata,
   output logic        mdc,
   inout  wire         mdio
);

   localparam int CW = DIV_LOG2 + 1;

   // Last count before the wrap (mdc about to fall) and last count before mdc rises.
   localparam logic [CW-1:0] CNT_LAST    = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_PRERISE = {1'b0, {DIV_LOG2{1'b1}}};

   // Index of the turnaround bit; reads release the line from here on.
   localparam logic [5:0] TA_BIT    = 6'd46;
   localparam logic [5:0] DATA_BIT  = 6'd48;
   localparam logic [5:0] FINAL_BIT = 6'd63;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] div_cnt;
   logic          bit_edge;
   logic          rise_edge;
   logic          start;
   logic          last_bit;
   logic [5:0]    bit_idx;
   logic [63:0]   frame_new;
   logic [63:0]   frame_sr;
   logic          we_l;
   logic          mdio_oe;
   logic [15:0]   rd_sr;

   assign bit_edge  = (div_cnt == CNT_LAST);
   assign rise_edge = (div_cnt == CNT_PRERISE);
   assign mdc       = div_cnt[CW-1];

   assign start    = (state == IDLE)  && bit_edge && req;
   assign last_bit = (state == FRAME) && bit_edge && (bit_idx == FINAL_BIT);

   // Whole frame, MSB first. For reads the TA/data field is never driven, so its content is don't-care.
   assign frame_new = {32'hFFFF_FFFF, 2'b01, (we ? 2'b01 : 2'b10), phyad, addr, 2'b10,
                       (we ? wdata : 16'h0000)};

   // Line is driven from a flop pair only, so it cannot glitch between boundaries.
   assign mdio = mdio_oe ? frame_sr[63] : 1'bz;

   // Free-running mdc divider; restarts from zero on reset so the first boundary is a full period later.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: accept on a boundary, run 64 bits, spend one clk in DONE for the ack.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = FRAME;
         FRAME:   if (last_bit) state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // FSM outputs: DONE lasts exactly one clk, which gives the single-cycle ack.
   always_comb begin
      ack = (state == DONE);
   end

   // Frame shifter and drive enable; both move only on bit boundaries.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         frame_sr <= '0;
         bit_idx  <= '0;
         we_l     <= 1'b0;
         mdio_oe  <= 1'b0;
      end else if (start) begin
         frame_sr <= frame_new;
         bit_idx  <= '0;
         we_l     <= we;
         mdio_oe  <= 1'b1;
      end else if ((state == FRAME) && bit_edge) begin
         frame_sr <= {frame_sr[62:0], 1'b0};
         bit_idx  <= bit_idx + 6'd1;
         if (bit_idx == FINAL_BIT) begin
            mdio_oe <= 1'b0;
         end else begin
            mdio_oe <= we_l || ((bit_idx + 6'd1) < TA_BIT);
         end
      end
   end

   // Read data is sampled at mdc rise, half a period after the PHY changed it on the fall.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         rd_sr <= '0;
      end else if ((state == FRAME) && rise_edge && (bit_idx >= DATA_BIT)) begin
         rd_sr <= {rd_sr[14:0], mdio};
      end
   end

   // rdata only changes when a read completes; writes leave the last read value visible.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         rdata <= '0;
      end else if (last_bit && !we_l) begin
         rdata <= rd_sr;
      end
   end

endmodule

// File: tb/tb_mii_mgmt.sv
// Bench for mii_mgmt: clock/reset generator, a clause-22 PHY on mdc/mdio answering at address 0x12,
// and a cycle-indexed model of what mdc/mdio/ack/rdata must show after every clk edge.
`timescale 1ns/1ps
module tb_mii_mgmt;

   localparam int          BIT        = 64;
   localparam int          FRAME_CLKS = 64 * BIT;
   localparam logic [4:0]  PHY_ADDR   = 5'h12;
   localparam logic [63:0] LIT_RD1C   = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b10010, 5'b11100, 2'b10, 16'hB91C};
   localparam logic [63:0] LIT_WR0A   = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b10010, 5'b01010, 2'b10, 16'hBEEF};
   localparam logic [63:0] LIT_RD0A   = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'b10010, 5'b01010, 2'b10, 16'hBEEF};

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  phyad;
   logic [4:0]  addr;
   logic [15:0] wdata;
   logic        req;
   logic        we;
   logic        ack;
   logic [15:0] rdata;
   logic        mdc;
   wire         mdio;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   mii_mgmt #(.DIV_LOG2(5)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .phyad  (phyad),
      .addr   (addr),
      .wdata  (wdata),
      .req    (req),
      .we     (we),
      .ack    (ack),
      .rdata  (rdata),
      .mdc    (mdc),
      .mdio   (mdio)
   );

   // 100 MHz clock
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   pullup (mdio);

   function automatic logic [15:0] init_val(input int i);
      return 16'hA500 ^ (16'(i) * 16'h0101);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- PHY model ----------------
   logic [15:0] phy_regs [32];
   logic [63:0] ph_hist;
   int          ph_bit;
   int          ph_nb;
   logic        ph_rd, ph_wr, ph_oe, ph_val;
   logic [4:0]  ph_ra;
   wire  [63:0] ph_next = {ph_hist[62:0], mdio};

   assign mdio = ph_oe ? ph_val : 1'bz;
   always_comb ph_nb = ph_bit + 1;

   // PHY receive side: hunt for preamble+ST, decode header, commit writes at the last bit
   always @(posedge mdc or posedge reset_n) begin
      if (reset_n) begin
         ph_hist <= '1;
         ph_bit  <= -1;
         ph_rd   <= 1'b0;
         ph_wr   <= 1'b0;
         ph_ra   <= '0;
         for (int i = 0; i < 32; i++) phy_regs[i] <= init_val(i);
      end else begin
         ph_hist <= ph_next;
         if (ph_bit < 0) begin
            if (ph_next[33:0] == {32'hFFFF_FFFF, 2'b01}) ph_bit <= 33;
         end else if (ph_nb == 45) begin
            ph_bit <= 45;
            ph_ra  <= ph_next[4:0];
            ph_rd  <= (ph_next[11:10] == 2'b10) && (ph_next[9:5] == PHY_ADDR);
            ph_wr  <= (ph_next[11:10] == 2'b01) && (ph_next[9:5] == PHY_ADDR);
         end else if (ph_nb == 63) begin
            if (ph_wr && ph_next[17:16] == 2'b10) phy_regs[ph_ra] <= ph_next[15:0];
            ph_bit <= -1;
            ph_rd  <= 1'b0;
            ph_wr  <= 1'b0;
         end else begin
            ph_bit <= ph_nb;
         end
      end
   end

   // PHY transmit side: TA zero then data on mdc falls of a read addressed to it
   always @(negedge mdc or posedge reset_n) begin
      if (reset_n) begin
         ph_oe  <= 1'b0;
         ph_val <= 1'b1;
      end else if (ph_rd && ph_nb == 47) begin
         ph_oe  <= 1'b1;
         ph_val <= 1'b0;
      end else if (ph_rd && ph_nb >= 48 && ph_nb <= 63) begin
         ph_oe  <= 1'b1;
         ph_val <= phy_regs[ph_ra][63 - ph_nb];
      end else begin
         ph_oe  <= 1'b0;
      end
   end

   // ---------------- behavioural model + per-cycle compare ----------------
   bit          armed = 1'b0;
   int          k = 0;
   bit          m_busy = 1'b0;
   int          m_start = 0;
   logic        m_we;
   logic [4:0]  m_pa, m_ad;
   logic [63:0] m_frame;
   logic [15:0] shadow [32];
   logic [15:0] e_rdata = 16'h0;
   logic [63:0] cap = '0;
   logic [63:0] last_frame = '0;

   initial forever begin
      logic e_ack;
      logic e_mdio;
      int   b;
      @(posedge clk);
      #1;
      e_ack = 1'b0;
      if (reset_n) begin
         armed   = 1'b1;
         k       = 0;
         m_busy  = 1'b0;
         e_rdata = 16'h0;
         for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
      end else if (armed) begin
         k++;
         if (m_busy && k == m_start + FRAME_CLKS) begin
            e_ack      = 1'b1;
            m_busy     = 1'b0;
            last_frame = cap;
            if (m_we) begin
               if (m_pa == PHY_ADDR) shadow[m_ad] = m_frame[15:0];
            end else begin
               e_rdata = (m_pa == PHY_ADDR) ? shadow[m_ad] : 16'hFFFF;
            end
         end else if (!m_busy && (k % BIT) == 0 && req) begin
            m_busy  = 1'b1;
            m_start = k;
            m_we    = we;
            m_pa    = phyad;
            m_ad    = addr;
            m_frame = {32'hFFFF_FFFF, 2'b01, (we ? 2'b01 : 2'b10), phyad, addr, 2'b10, (we ? wdata : 16'h0)};
            cap     = '0;
         end
         if (m_busy && ((k - m_start) % BIT) == 40) cap[63 - (k - m_start) / BIT] = mdio;
      end
      if (armed) begin
         e_mdio = 1'b1;
         if (m_busy) begin
            b = (k - m_start) / BIT;
            if (m_we || b < 46)         e_mdio = m_frame[63 - b];
            else if (b == 46)           e_mdio = 1'b1;
            else if (m_pa != PHY_ADDR)  e_mdio = 1'b1;
            else if (b == 47)           e_mdio = 1'b0;
            else                        e_mdio = shadow[m_ad][63 - b];
         end
         check("mdc",   64'(mdc),   64'((k % BIT) >= 32));
         check("ack",   64'(ack),   64'(e_ack));
         check("rdata", 64'(rdata), 64'(e_rdata));
         check("mdio",  64'(mdio),  64'(e_mdio));
      end
   end

   // mdc period and duty after reset release
   initial begin
      time t0, t1, t2;
      t0 = 0; t1 = 0; t2 = 0;
      @(negedge reset_n);
      fork
         begin
            @(posedge mdc); t0 = $time;
            @(negedge mdc); t1 = $time;
            @(posedge mdc); t2 = $time;
         end
         begin
            #5000;
         end
      join_any
      disable fork;
      check("mdc_period_ns", 64'(t2 - t0), 64'd640);
      check("mdc_high_ns",   64'(t1 - t0), 64'd320);
   end

   // ---------------- stimulus ----------------
   int ack_cyc;

   task automatic run_txn(input logic [4:0] pa, input logic [4:0] ad, input logic [15:0] wd,
                          input logic w, input int hold, input bit scramble);
      int n;
      phyad = pa; addr = ad; wdata = wd; we = w; req = 1'b1;
      n = 0;
      while (!m_busy && n < 300) begin @(negedge clk); n++; end
      if (!m_busy) check("txn_start_timeout", 64'd1, 64'd0);
      if (scramble) begin
         repeat ($urandom_range(10, 1500)) @(negedge clk);
         phyad = 5'($urandom); addr = 5'($urandom); wdata = 16'($urandom); we = 1'($urandom);
         req = 1'b0;
         repeat ($urandom_range(1, 100)) @(negedge clk);
         req = 1'b1;
      end
      n = 0;
      while (!ack && n < 6000) begin @(negedge clk); n++; end
      if (!ack) check("txn_ack_timeout", 64'd1, 64'd0);
      ack_cyc = cyc;
      if (hold >= 0) begin
         repeat (hold) @(negedge clk);
         req = 1'b0;
      end
   endtask

   initial begin
      int rel_cyc, ack2, n, hold;
      logic [4:0] pa;
      reset_n = 1'b0; req = 1'b0; we = 1'b0; phyad = '0; addr = '0; wdata = '0;
      #2 reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // read 0x1C, request already pending when reset releases
      phyad = PHY_ADDR; addr = 5'h1C; we = 1'b0; req = 1'b1;
      rel_cyc = cyc;
      reset_n = 1'b0;
      run_txn(PHY_ADDR, 5'h1C, 16'h0, 1'b0, 0, 1'b0);
      check("rd1c_frame",   last_frame, LIT_RD1C);
      check("rd1c_rdata",   64'(rdata), 64'hB91C);
      check("first_ack_lat", 64'(ack_cyc - rel_cyc), 64'd4160);

      // write 0xBEEF to 0x0A, then read it back with req never dropping
      run_txn(PHY_ADDR, 5'h0A, 16'hBEEF, 1'b1, -1, 1'b0);
      ack2 = ack_cyc;
      check("wr0a_frame", last_frame, LIT_WR0A);
      check("wr0a_rdata", 64'(rdata), 64'hB91C);
      check("wr0a_phyreg", 64'(phy_regs[10]), 64'hBEEF);
      run_txn(PHY_ADDR, 5'h0A, 16'h0, 1'b0, 1, 1'b0);
      check("rd0a_frame",   last_frame, LIT_RD0A);
      check("rd0a_rdata",   64'(rdata), 64'hBEEF);
      check("b2b_ack_gap",  64'(ack_cyc - ack2), 64'd4160);
      repeat (300) @(negedge clk);

      // reset during bit 40 of a read
      phyad = PHY_ADDR; addr = 5'h05; we = 1'b0; req = 1'b1;
      n = 0;
      while (!(m_busy && (k - m_start) >= 40 * BIT + 10) && n < 6000) begin @(negedge clk); n++; end
      if (!m_busy) check("abort_start_timeout", 64'd1, 64'd0);
      reset_n = 1'b1; req = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_rdata", 64'(rdata), 64'h0);
      check("abort_mdc",   64'(mdc),   64'h0);
      check("abort_ack",   64'(ack),   64'h0);
      reset_n = 1'b0;
      repeat (100) @(negedge clk);
      run_txn(PHY_ADDR, 5'h1C, 16'h0, 1'b0, 0, 1'b0);
      check("post_abort_rdata", 64'(rdata), 64'hB91C);

      // randomized traffic, mixed gaps, inputs disturbed mid-frame
      for (int it = 0; it < 6; it++) begin
         pa = ($urandom_range(0, 2) != 0) ? PHY_ADDR : 5'($urandom);
         case ($urandom_range(0, 3))
            0:       hold = -1;
            1:       hold = 0;
            2:       hold = 1;
            default: hold = $urandom_range(2, 60);
         endcase
         if (it == 5 && hold < 0) hold = 0;
         run_txn(pa, 5'($urandom), 16'($urandom), 1'($urandom), hold, 1'b1);
         if (hold >= 0) repeat ($urandom_range(0, 150)) @(negedge clk);
      end
      repeat (200) @(negedge clk);

      for (int i = 0; i < 32; i++) check("phy_reg_vs_model", 64'(phy_regs[i]), 64'(shadow[i]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
